// File: rtl/run_control_pkg.sv
// rtl/run_control_pkg.sv - shared state and mode encodings for run_control
package run_control_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_BURST  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   // Modes 2 and 3 are reserved and fall through to free-running.
   localparam logic [1:0] MODE_FREE  = 2'd0;
   localparam logic [1:0] MODE_BURST = 2'd1;

endpackage

// File: rtl/run_control_button_debounce.sv
// rtl/run_control_button_debounce.sv - button synchroniser, debouncer and press detector
//   clk     system clock
//   reset   synchronous active-high reset
//   i_raw   raw asynchronous button level
//   o_press one-cycle pulse on each accepted 0->1 transition
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 65536
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   output logic o_press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

   logic [1:0]    r_sync;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_cnt;

   logic w_diff;
   logic w_done;

   // r_cnt counts consecutive synchronised samples that disagree with the
   // accepted level; the level flips on the DEBOUNCE_CYCLES-th such sample.
   assign w_diff = r_sync[1] ^ r_level;
   assign w_done = (r_cnt == CW'(DEBOUNCE_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync  <= 2'b00;
         r_level <= 1'b0;
         r_press <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync  <= {r_sync[0], i_raw};
         r_press <= 1'b0;
         if (!w_diff) begin
            r_cnt <= '0;
         end else if (w_done) begin
            r_cnt   <= '0;
            r_level <= r_sync[1];
            r_press <= r_sync[1];
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/run_control.sv
// rtl/run_control.sv - run/pause/step/burst CPU clock-enable controller
//   clk, reset   system clock, synchronous active-high reset
//   start, step  raw run/pause and single-step buttons
//   mode         0 free-run, 1 burst, 2/3 free-run
//   div_ratio    enable period minus one
//   burst_len    enables issued per burst
//   halt_req     level halt request
//   cpu_en       registered one-clk CPU enable pulse
//   running      high in RUN or BURST
//   halted       high in HALTED
//   cycle_count  total cpu_en pulses issued (wrapping)
module run_control
   import run_control_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 65536,
   parameter int DIV_W           = 24,
   parameter int BURST_W         = 16,
   parameter int CNT_W           = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               step,
   input  logic [1:0]         mode,
   input  logic [DIV_W-1:0]   div_ratio,
   input  logic [BURST_W-1:0] burst_len,
   input  logic               halt_req,
   output logic               cpu_en,
   output logic               running,
   output logic               halted,
   output logic [CNT_W-1:0]   cycle_count
);

   state_t             r_state;
   logic [DIV_W-1:0]   r_div;
   logic [BURST_W-1:0] r_remaining;
   logic               r_cpu_en;
   logic               r_running;
   logic               r_halted;
   logic [CNT_W-1:0]   r_cycle_count;

   logic w_start_press;
   logic w_step_press;
   logic w_active;
   logic w_tick;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (start),
      .o_press (w_start_press)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_btn (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (step),
      .o_press (w_step_press)
   );

   assign w_active = (r_state == ST_RUN) || (r_state == ST_BURST);
   assign w_tick   = w_active && (r_div == div_ratio);

   // Held at zero outside RUN/BURST so each entry starts a fresh period. A
   // live decrease of div_ratio below r_div simply wraps through the full range.
   always_ff @(posedge clk) begin
      if (reset || !w_active) begin
         r_div <= '0;
      end else if (w_tick) begin
         r_div <= '0;
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cycle_count <= '0;
      end else if (r_cpu_en) begin
         r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_remaining <= '0;
         r_cpu_en    <= 1'b0;
         r_running   <= 1'b0;
         r_halted    <= 1'b0;
      end else begin
         r_cpu_en <= 1'b0;
         // Halt wins over start, step and tick from every state but HALTED.
         if (halt_req && (r_state != ST_HALTED)) begin
            r_state   <= ST_HALTED;
            r_running <= 1'b0;
            r_halted  <= 1'b1;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start_press) begin
                     if (mode == MODE_BURST) begin
                        if (burst_len != '0) begin
                           r_state     <= ST_BURST;
                           r_remaining <= burst_len;
                           r_running   <= 1'b1;
                        end
                     end else begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                     end
                  end else if (w_step_press) begin
                     r_cpu_en <= 1'b1;
                  end
               end
               ST_RUN: begin
                  if (w_start_press) begin
                     r_state   <= ST_IDLE;
                     r_running <= 1'b0;
                  end else if (w_tick) begin
                     r_cpu_en <= 1'b1;
                  end
               end
               ST_BURST: begin
                  if (w_start_press) begin
                     r_state   <= ST_IDLE;
                     r_running <= 1'b0;
                  end else if (w_tick) begin
                     r_cpu_en    <= 1'b1;
                     r_remaining <= r_remaining - BURST_W'(1);
                     if (r_remaining == BURST_W'(1)) begin
                        r_state   <= ST_IDLE;
                        r_running <= 1'b0;
                     end
                  end
               end
               ST_HALTED: begin
                  if (w_start_press && !halt_req) begin
                     r_state  <= ST_IDLE;
                     r_halted <= 1'b0;
                  end
               end
               default: begin
                  r_state   <= ST_IDLE;
                  r_running <= 1'b0;
                  r_halted  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign cpu_en      = r_cpu_en;
   assign running     = r_running;
   assign halted      = r_halted;
   assign cycle_count = r_cycle_count;

endmodule

// File: tb/tb_run_control.sv
// tb/tb_run_control.sv - scoreboard bench for run_control
module tb_run_control;

   localparam int D = 4;
   localparam logic [31:0] MASK = (32'd1 << D) - 32'd1;
   localparam int M_IDLE = 0, M_RUN = 1, M_BURST = 2, M_HALT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       step = 1'b0;
   logic       halt_req = 1'b0;
   logic [1:0] mode = 2'd0;
   logic [7:0] div_ratio = 8'd0;
   logic [7:0] burst_len = 8'd0;
   wire        cpu_en;
   wire        running;
   wire        halted;
   wire  [3:0] cycle_count;

   run_control #(.DEBOUNCE_CYCLES(D), .DIV_W(8), .BURST_W(8), .CNT_W(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .step        (step),
      .mode        (mode),
      .div_ratio   (div_ratio),
      .burst_len   (burst_len),
      .halt_req    (halt_req),
      .cpu_en      (cpu_en),
      .running     (running),
      .halted      (halted),
      .cycle_count (cycle_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int exp_q[$];
   int w_pop;

   // reference model state
   int          m_st = M_IDLE;
   int          m_n = 0;
   int          m_rem = 0;
   int          m_en = 0;
   int          m_cnt = 0;
   bit          lvl[2];
   bit          pr[2];
   logic [1:0]  pipe[2];
   logic [31:0] hist[2];
   bit          raw_b[2];
   bit          sp, tp, tick, en_new;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   always @(posedge clk) begin
      cyc++;
      raw_b[0] = start;
      raw_b[1] = step;
      if (reset) begin
         m_st = M_IDLE; m_n = 0; m_rem = 0; m_en = 0; m_cnt = 0;
         for (int b = 0; b < 2; b++) begin
            lvl[b] = 0; pr[b] = 0; pipe[b] = 2'b00; hist[b] = 32'd0;
         end
      end else begin
         sp = pr[0];
         tp = pr[1];
         en_new = 0;
         tick = 0;
         if (m_st == M_RUN || m_st == M_BURST) begin
            tick = (m_n % (int'(div_ratio) + 1)) == int'(div_ratio);
            m_n++;
         end
         if (halt_req && m_st != M_HALT) begin
            m_st = M_HALT;
         end else begin
            case (m_st)
               M_IDLE: begin
                  if (sp) begin
                     if (mode == 2'd1) begin
                        if (burst_len != 0) begin
                           m_st = M_BURST; m_rem = burst_len; m_n = 0;
                        end
                     end else begin
                        m_st = M_RUN; m_n = 0;
                     end
                  end else if (tp) begin
                     en_new = 1;
                  end
               end
               M_RUN, M_BURST: begin
                  if (sp) m_st = M_IDLE;
                  else if (tick) begin
                     en_new = 1;
                     if (m_st == M_BURST) begin
                        m_rem--;
                        if (m_rem == 0) m_st = M_IDLE;
                     end
                  end
               end
               default: if (sp && !halt_req) m_st = M_IDLE;
            endcase
         end
         m_cnt = (m_cnt + m_en) % 16;
         m_en = en_new;
         if (en_new) exp_q.push_back(cyc);
         // Two-stage synchroniser delay, then accept a new level once the last
         // D synchronised samples all disagree with the current one.
         for (int b = 0; b < 2; b++) begin
            hist[b] = {hist[b][30:0], pipe[b][1]};
            pipe[b] = {pipe[b][0], raw_b[b]};
            pr[b] = 0;
            if ((lvl[b] == 0 && (hist[b] & MASK) == MASK) ||
                (lvl[b] == 1 && (hist[b] & MASK) == 32'd0)) begin
               lvl[b] = ~lvl[b];
               pr[b] = lvl[b];
            end
         end
      end
   end

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
         total++;
         bad++;
         $display("FAIL missed_pulse got=none want_cycle=%0d", exp_q[0]);
         w_pop = exp_q.pop_front();
      end
      if (cpu_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_pulse got_cycle=%0d want=none", cyc);
         end else begin
            w_pop = exp_q.pop_front();
            check("pulse_cycle", cyc, w_pop);
         end
      end
      if (!reset && (cyc % 16 == 0)) begin
         check("running", int'(running), int'(m_st == M_RUN || m_st == M_BURST));
         check("halted", int'(halted), int'(m_st == M_HALT));
         check("cycle_count", int'(cycle_count), m_cnt);
      end
   end

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      step = 1'b0;
      halt_req = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic press(input int which, input int hold, input int gap);
      if (which == 0) start = 1'b1; else step = 1'b1;
      repeat (hold) @(negedge clk);
      if (which == 0) start = 1'b0; else step = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   initial begin
      bit found;
      @(negedge clk);
      @(negedge clk);
      check("reset_cpu_en", int'(cpu_en), 0);
      check("reset_running", int'(running), 0);
      check("reset_halted", int'(halted), 0);
      check("reset_count", int'(cycle_count), 0);
      reset = 1'b0;

      // long step hold then a short glitch
      press(1, 10, 12);
      check("step_count", int'(cycle_count), 1);
      press(1, 3, 12);
      check("glitch_count", int'(cycle_count), 1);

      // free run, div 3, then stop
      mode = 2'd0; div_ratio = 8'd3;
      press(0, 6, 30);
      check("run_running", int'(running), 1);
      press(0, 6, 12);
      check("run_stopped", int'(running), 0);
      repeat (10) @(negedge clk);

      // burst of 5 with div 0, then zero-length burst
      do_reset();
      mode = 2'd1; burst_len = 8'd5; div_ratio = 8'd0;
      press(0, 6, 20);
      check("burst_count", int'(cycle_count), 5);
      check("burst_done", int'(running), 0);
      burst_len = 8'd0;
      press(0, 6, 12);
      check("burst0_idle", int'(running), 0);
      check("burst0_count", int'(cycle_count), 5);

      // halt coincident with a tick
      do_reset();
      mode = 2'd0; div_ratio = 8'd3;
      press(0, 6, 0);
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (m_st == M_RUN && (m_n % 4) == 3) found = 1;
         else @(negedge clk);
      end
      check("halt_align_found", int'(found), 1);
      halt_req = 1'b1;
      @(negedge clk);
      check("halt_no_pulse", int'(cpu_en), 0);
      check("halt_halted", int'(halted), 1);
      press(0, 6, 12);
      check("halt_held", int'(halted), 1);
      halt_req = 1'b0;
      press(0, 6, 12);
      check("halt_release", int'(halted), 0);
      check("halt_release_run", int'(running), 0);

      // reset mid-burst at remaining 3
      do_reset();
      mode = 2'd1; burst_len = 8'd8; div_ratio = 8'd0;
      start = 1'b1;
      found = 0;
      for (int i = 0; i < 60 && !found; i++) begin
         @(negedge clk);
         if (m_st == M_BURST && m_rem == 3) found = 1;
      end
      check("burst_rem3_found", int'(found), 1);
      reset = 1'b1;
      start = 1'b0;
      @(negedge clk);
      check("rst_cpu_en", int'(cpu_en), 0);
      check("rst_running", int'(running), 0);
      check("rst_count", int'(cycle_count), 0);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      check("rst_no_pulse_count", int'(cycle_count), 0);

      // counter wrap
      do_reset();
      for (int i = 0; i < 17; i++) press(1, 5, 10);
      check("wrap_count", int'(cycle_count), 1);

      // randomized traffic
      do_reset();
      for (int it = 0; it < 150; it++) begin
         int act;
         mode = 2'($urandom_range(0, 3));
         burst_len = 8'($urandom_range(0, 6));
         if (m_st == M_IDLE || m_st == M_HALT) div_ratio = 8'($urandom_range(0, 4));
         act = $urandom_range(0, 9);
         if (act < 4) press(0, $urandom_range(1, 8), $urandom_range(0, 12));
         else if (act < 6) press(1, $urandom_range(1, 8), $urandom_range(0, 12));
         else if (act == 6) begin
            halt_req = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            halt_req = 1'b0;
         end else repeat ($urandom_range(1, 20)) @(negedge clk);
      end
      halt_req = 1'b0;
      repeat (30) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/run_control.md
RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 65536: clk cycles a synchronised button level must hold before it is accepted.
REQ-002 SHALL have parameter DIV_W, default 24: width of the run-rate divider ratio.
REQ-003 SHALL have parameter BURST_W, default 16: width of the burst length.
REQ-004 SHALL have parameter CNT_W, default 32: width of the issued-cycle counter.
REQ-005 SHALL have ports, one clock and one reset; reset is synchronous and active-high:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- start  in  1  raw asynchronous run/pause button
- step  in  1  raw asynchronous single-step button
- mode  in  2  run mode: 0 FREE, 1 BURST, 2/3 reserved, treated as FREE
- div_ratio  in  DIV_W  enable period minus one
- burst_len  in  BURST_W  enables issued per burst
- halt_req  in  1  level halt request from the CPU
- cpu_en  out  1  one-clk CPU clock-enable pulse, registered
- running  out  1  high in RUN or BURST
- halted  out  1  high in HALTED
- cycle_count  out  CNT_W  total cpu_en pulses issued

Function
REQ-006 SHALL pass start and step each through a 2-flop synchroniser, then a debouncer; the debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples.
REQ-007 SHALL produce a one-cycle press pulse on each debounced 0->1 transition, and none on release.
REQ-008 SHALL have states IDLE, RUN, BURST and HALTED; reset state is IDLE.
REQ-009 IDLE: on a start press with mode FREE/reserved, SHALL go to RUN; with mode BURST and burst_len!=0, SHALL go to BURST and load remaining=burst_len; with burst_len==0, SHALL stay in IDLE.
REQ-010 IDLE: on a step press, SHALL assert cpu_en for exactly one cycle, in the cycle after the press, and stay in IDLE.
REQ-011 The divider SHALL count 0..div_ratio and generate a tick when count==div_ratio, then wrap to 0; it is cleared on entry to RUN or BURST, so the first tick comes div_ratio+1 cycles after entry.
REQ-012 div_ratio==0 SHALL produce a tick every cycle; div_ratio SHALL be sampled live, and a decrease below the current count SHALL wrap via the full DIV_W range without error.
REQ-013 In RUN or BURST, each tick SHALL give cpu_en=1 in the next cycle.
REQ-014 BURST: each tick SHALL decrement remaining; the tick that takes remaining to 0 SHALL return to IDLE, so exactly burst_len pulses are issued.
REQ-015 RUN/BURST: a start press SHALL return to IDLE, and no cpu_en is issued for a tick in that same cycle.
REQ-016 halt_req high in any state other than HALTED SHALL move to HALTED next cycle and suppress any cpu_en that would be issued next cycle; halt_req has priority over start, step and tick.
REQ-017 HALTED: cpu_en SHALL stay 0 and step presses SHALL be ignored; a start press with halt_req low SHALL go to IDLE.
REQ-018 mode and burst_len SHALL be sampled only at the IDLE start press; changes mid-run have no effect.
REQ-019 cycle_count SHALL increment on every cpu_en pulse and wrap modulo 2^CNT_W.

Reset
REQ-020 reset SHALL give: state IDLE, cpu_en 0, running 0, halted 0, cycle_count 0, divider 0, remaining 0, synchronisers and debouncers 0 with no press pending.
REQ-021 reset asserted mid-burst or mid-debounce SHALL abort it with no further cpu_en pulse.

Structure
REQ-022 The state enum and mode encodings SHALL reside in shared package run_control_pkg.
REQ-023 Synchroniser, debouncer and press detector SHALL be one sub-module, button_debounce, instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-024 step held for 10 cycles in IDLE -> exactly one cpu_en, cycle_count=1; a 3-cycle glitch -> no pulse.
REQ-025 mode=0, div_ratio=3, start press -> cpu_en every 4th cycle, with the first pulse 5 cycles after entering RUN; a second start press -> IDLE, and pulses stop.
REQ-026 mode=1, burst_len=5, div_ratio=0 -> 5 consecutive cpu_en pulses, then IDLE, cycle_count=5; burst_len=0 -> state stays IDLE.
REQ-027 RUN with halt_req raised in the same cycle as a tick -> no cpu_en the next cycle, halted=1; start press with halt_req still high -> stays HALTED; after halt_req falls, start press -> IDLE.
REQ-028 reset during BURST with remaining=3 -> next cycle all outputs 0, and no pulse follows.
REQ-029 CNT_W=4, 17 step presses -> cycle_count wraps to 1.
